// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: buffered immediate / load-data extension unit.
//
// Each accepted transaction is extended according to in_op. The result is
// then pushed into a DEPTH-entry FIFO that has valid/ready handshakes on both
// sides.
//   op 0 ZEXT  : zero-extend in_imm
//   op 1 SEXT  : sign-extend in_imm
//   op 2 LUI   : in_imm in the top IN_W bits
//   op 3 BOFF  : SEXT result shifted left by 2
//   op 4 LBU   : byte lane in_off of in_word, zero-extended
//   op 5 LB    : same byte, sign-extended
//   op 6 LHU   : halfword lane in_off[OFF_W-1:1], zero-extended
//   op 7 LH    : same halfword, sign-extended
// Ops 6 and 7 with in_off[0]=1 set the per-entry err bit.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   flush              synchronous FIFO clear; has priority over push/pop
//   in_valid/in_ready  producer handshake
//   in_op/in_imm/in_word/in_off  transaction operands
//   out_valid/out_ready consumer handshake
//   out_data/out_err   head entry result and misaligned-halfword flag
//   count              current occupancy
module ext_unit_pipe #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned OFF_W = $clog2(OUT_W / 8),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [OUT_W-1:0] in_word,
    input  logic [OFF_W-1:0] in_off,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OpZext = 3'd0,
        OpSext = 3'd1,
        OpLui  = 3'd2,
        OpBoff = 3'd3,
        OpLbu  = 3'd4,
        OpLb   = 3'd5,
        OpLhu  = 3'd6,
        OpLh   = 3'd7
    } op_e;

    logic [OUT_W-1:0] mem_data [DEPTH];
    logic             mem_err  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push;
    logic             pop;

    logic [OUT_W-1:0] sext;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;

    // Extension datapath
    always_comb begin
        sext      = {{(OUT_W - IN_W){in_imm[IN_W-1]}}, in_imm};
        lane_byte = in_word[{in_off, 3'b000} +: 8];
        // The halfword lane ignores in_off[0]; misalignment only raises err.
        lane_half = in_word[{in_off[OFF_W-1:1], 4'b0000} +: 16];
        ext_data  = '0;
        ext_err   = 1'b0;
        case (op_e'(in_op))
            OpZext: ext_data = {{(OUT_W - IN_W){1'b0}}, in_imm};
            OpSext: ext_data = sext;
            OpLui:  ext_data = {in_imm, {(OUT_W - IN_W){1'b0}}};
            OpBoff: ext_data = sext << 2;
            OpLbu:  ext_data = {{(OUT_W - 8){1'b0}}, lane_byte};
            OpLb:   ext_data = {{(OUT_W - 8){lane_byte[7]}}, lane_byte};
            OpLhu: begin
                ext_data = {{(OUT_W - 16){1'b0}}, lane_half};
                ext_err  = in_off[0];
            end
            OpLh: begin
                ext_data = {{(OUT_W - 16){lane_half[15]}}, lane_half};
                ext_err  = in_off[0];
            end
            default: begin
                ext_data = '0;
                ext_err  = 1'b0;
            end
        endcase
    end

    // Handshake. in_ready looks only at local state and flush, never out_ready,
    // so a full FIFO refuses a push even when it is popped in the same cycle.
    always_comb begin
        in_ready  = reset_n && (count_q != CNT_W'(DEPTH)) && !flush;
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_data  = mem_data[rd_ptr_q];
        out_err   = mem_err[rd_ptr_q];
        count     = count_q;
    end

    // Pointer / occupancy next state; wrap by explicit compare for any DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage clears on reset so out_data/out_err read 0 while in reset.
    // Flush leaves contents alone; out_valid already masks them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_data[i] <= '0;
                mem_err[i]  <= 1'b0;
            end
        end else if (push) begin
            mem_data[wr_ptr_q] <= ext_data;
            mem_err[wr_ptr_q]  <= ext_err;
        end
    end

endmodule
